// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Brief    : Assembles a big-endian byte stream into 32-bit words, writes them
//            to instruction memory and holds the CPU in reset until done.
//            Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
module inst_loader #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LEN_HI = 3'd1;
    localparam logic [2:0] c_LEN_LO = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_WRITE  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM       = 3'd7;
    localparam logic [2:0] c_AFTER_LAST = c_CSUM;
`else
    localparam logic [2:0] c_AFTER_LAST = c_DONE;
`endif

    localparam logic [31:0] c_DEPTH = 32'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_len_hi;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_idx;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_words;
    logic              r_ready;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_rst;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_xfer;
    logic [LEN_W-1:0]  w_n;
    logic [LEN_W-1:0]  w_words_inc;
    logic              w_next_busy;

    assign w_xfer      = byte_valid && r_ready;
    assign w_n         = LEN_W'({r_len_hi, byte_in});
    assign w_words_inc = r_words + LEN_W'(1);
    assign w_next_busy = (w_next != c_IDLE) && (w_next != c_DONE) && (w_next != c_ERR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERR: begin
                if (start) w_next = c_LEN_HI;
            end
            c_LEN_HI: begin
                if (w_xfer) w_next = c_LEN_LO;
            end
            c_LEN_LO: begin
                if (w_xfer) begin
                    if (w_n == '0)
                        w_next = c_AFTER_LAST;
                    else if (32'(w_n) > c_DEPTH)
                        w_next = c_ERR;
                    else
                        w_next = c_DATA;
                end
            end
            c_DATA: begin
                if (w_xfer && (r_idx == 2'd3)) w_next = c_WRITE;
            end
            c_WRITE: begin
                w_next = (w_words_inc == r_len) ? c_AFTER_LAST : c_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            c_CSUM: begin
                if (w_xfer) w_next = (byte_in == r_csum) ? c_DONE : c_ERR;
            end
`endif
            default: w_next = c_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_IDLE;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_addr    <= '0;
            r_words   <= '0;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_state   <= w_next;
            r_ready   <= w_next_busy && (w_next != c_WRITE);
            r_we      <= (w_next == c_WRITE);
            r_busy    <= w_next_busy;
            r_done    <= (w_next == c_DONE);
            r_err     <= (w_next == c_ERR);
            r_cpu_rst <= (w_next != c_DONE);
            case (r_state)
                c_IDLE, c_DONE, c_ERR: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_words <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                c_LEN_HI: begin
                    if (w_xfer) r_len_hi <= byte_in;
                end
                c_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_n;
                        r_idx <= '0;
                    end
                end
                c_DATA: begin
                    if (w_xfer) begin
                        r_wdata <= {r_wdata[23:0], byte_in};
                        r_idx   <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ byte_in;
`endif
                    end
                end
                c_WRITE: begin
                    // Address wraps modulo DEPTH; N never exceeds DEPTH so no overwrite.
                    r_words <= w_words_inc;
                    r_addr  <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign byte_ready   = r_ready;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign cpu_rst      = r_cpu_rst;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Self-checking bench for inst_loader: vector table of loads plus
//            directed reset, oversize, full-depth and abort sequences.
// Revision : 1.0
// ============================================================================
module tb_inst_loader;

    localparam int c_ADDR_W = 6;
    localparam int c_LEN_W  = 16;

    logic                CLK = 1'b0;
    logic                RST;
    logic                start;
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic                mem_we;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic                cpu_rst;
    logic                busy;
    logic                done;
    logic                err;
    logic [c_LEN_W-1:0]  words_loaded;

    inst_loader #(.ADDR_W(c_ADDR_W), .LEN_W(c_LEN_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        bit          poke;
    } vec_t;

    vec_t                vecs[6];
    logic [31:0]         wbuf[64];
    logic [c_ADDR_W-1:0] wr_addr[$];
    logic [31:0]         wr_data[$];
    int                  we_ready_clash = 0;
    int                  n_checks = 0;
    int                  n_pass = 0;

    // Write-strobe monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (byte_ready) we_ready_clash++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        int t;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        taken = 1'b0;
        t = 0;
        while (!taken && t < 50) begin
            taken = byte_ready;
            tick();
            t++;
        end
        byte_valid = 1'b0;
        if (!taken) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_load(input logic [15:0] n, input int gap, input logic [7:0] flip, input bit poke);
        logic [7:0] csum;
        logic [7:0] b;
        int t;
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(n[15:8], 0);
        send_byte(n[7:0], gap);
        csum = 8'h00;
        if (n != 16'd0 && n <= 16'd64) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = wbuf[i][31-8*k -: 8];
                    csum = csum ^ b;
                    if (poke && i == 0 && k == 0) start = 1'b1;
                    send_byte(b, gap);
                    start = 1'b0;
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (n <= 16'd64) send_byte(csum ^ flip, gap);
`else
        if (flip != 8'h00) csum = csum ^ flip;
`endif
        t = 0;
        while (!(done || err) && t < 50) begin
            tick();
            t++;
        end
        if (!(done || err)) check("finish_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] n, input bit exp_ok);
        int exp_words;
        exp_words = (n <= 16'd64) ? int'(n) : 0;
        check({tag, "_done"},    32'(done),         32'(exp_ok));
        check({tag, "_err"},     32'(err),          32'(!exp_ok));
        check({tag, "_cpu_rst"}, 32'(cpu_rst),      32'(!exp_ok));
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_ready"},   32'(byte_ready),   32'd0);
        check({tag, "_words"},   32'(words_loaded), 32'(exp_words));
        check({tag, "_wcount"},  32'(wr_addr.size()), 32'(exp_words));
        for (int i = 0; i < wr_addr.size() && i < exp_words; i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("%s_wr%0d_data", tag, i), wr_data[i], wbuf[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd2,      32'h20010005, 32'h0000000A, 32'h0,        0, 1'b0};
        vecs[1] = '{16'd2,      32'h20010005, 32'h0000000A, 32'h0,        1, 1'b0};
        vecs[2] = '{16'd0,      32'h0,        32'h0,        32'h0,        0, 1'b0};
        vecs[3] = '{16'd1,      32'hDEADBEEF, 32'h0,        32'h0,        0, 1'b1};
        vecs[4] = '{16'd3,      32'h11223344, 32'h55667788, 32'h99AABBCC, 2, 1'b0};
        vecs[5] = '{16'hFFFF,   32'h0,        32'h0,        32'h0,        0, 1'b0};

        RST = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        repeat (3) tick();
        RST = 1'b0;

        // Idle after reset with no start.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle%0d", i),
                  {27'd0, cpu_rst, byte_ready, mem_we, done, busy}, {27'd0, 5'b10000});
            tick();
        end
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_words", 32'(words_loaded), 32'd0);

        for (int v = 0; v < 6; v++) begin
            wbuf[0] = vecs[v].w0;
            wbuf[1] = vecs[v].w1;
            wbuf[2] = vecs[v].w2;
            run_load(vecs[v].n, vecs[v].gap, 8'h00, vecs[v].poke);
            check_result($sformatf("v%0d", v), vecs[v].n, vecs[v].n <= 16'd64);
        end

        // Oversize header by one word; subsequent bytes must be refused.
        run_load(16'd65, 0, 8'h00, 1'b0);
        check_result("over", 16'd65, 1'b0);
        byte_in = 8'h5A;
        byte_valid = 1'b1;
        repeat (4) begin
            tick();
            check("over_hold_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        check("over_hold_wcount", 32'(wr_addr.size()), 32'd0);
        check("over_hold_err", 32'(err), 32'd1);

        // Full-depth load: last write at DEPTH-1, no wrap write afterwards.
        for (int i = 0; i < 64; i++) wbuf[i] = {8'(i), 8'hA5, ~8'(i), 8'(i * 3)};
        run_load(16'd64, 0, 8'h00, 1'b0);
        check_result("full", 16'd64, 1'b1);
        repeat (3) tick();
        check("full_no_wrap", 32'(wr_addr.size()), 32'd64);

        // Reset in the middle of the first word.
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        RST = 1'b1;
        tick();
        check("abort_ready",   32'(byte_ready),   32'd0);
        check("abort_we",      32'(mem_we),       32'd0);
        check("abort_addr",    32'(mem_addr),     32'd0);
        check("abort_wdata",   mem_wdata,         32'd0);
        check("abort_busy",    32'(busy),         32'd0);
        check("abort_done",    32'(done),         32'd0);
        check("abort_err",     32'(err),          32'd0);
        check("abort_words",   32'(words_loaded), 32'd0);
        check("abort_cpu_rst", 32'(cpu_rst),      32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_ready", 32'(byte_ready), 32'd0);
        RST = 1'b0;
        tick();
        check("abort_wcount", 32'(wr_addr.size()), 32'd0);
        wbuf[0] = 32'hCAFEF00D;
        run_load(16'd1, 0, 8'h00, 1'b0);
        check_result("after_abort", 16'd1, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        wbuf[0] = 32'h12345678;
        run_load(16'd1, 0, 8'h00, 1'b0);
        check_result("csum_ok", 16'd1, 1'b1);
        run_load(16'd1, 0, 8'h08, 1'b0);
        check_result("csum_bad", 16'd1, 1'b0);
`endif

        check("we_with_ready", 32'(we_ready_clash), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the CPU instruction-fetch path: fills instruction memory that the fetch unit later reads by PC.
- Accepts a byte stream over a valid/ready handshake from a host/IO source and assembles big-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU in reset until a load completes, so the core never fetches uninitialised code.

Parameters:
- ADDR_W, 6, word-address width of instruction memory; DEPTH = 2**ADDR_W words.
- LEN_W, 16, width of the word-count header.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write (CPU PC[ADDR_W+1:2]).
- mem_wdata  output  32  assembled instruction word.
- cpu_rst  output  1  reset to CPU core (PC/register file).
- busy  output  1  load in progress.
- done  output  1  last load completed successfully; held high.
- err  output  1  last load aborted; held high.
- words_loaded  output  LEN_W  words written in the current/last load.

Behaviour:
- Reset (RST=1 at a clock edge): state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_loaded=0, cpu_rst=1.
- RST during a load aborts immediately. Memory is left partially written. All outputs return to reset values.
- Handshake: a byte is transferred on any edge with byte_valid && byte_ready. byte_in is ignored otherwise. byte_ready is registered: high only in LEN_HI, LEN_LO, DATA.
- Stream format: N[15:8], N[7:0], then N words of 4 bytes each, MSB first.
- States:
  - IDLE: wait for start, then go to LEN_HI. Set busy=1, cpu_rst=1, done=0, err=0, words_loaded=0, mem_addr=0.
  - LEN_HI: take the high byte of N, go to LEN_LO.
  - LEN_LO: take the low byte of N.
    - If N=0: go to DONE.
    - If N>DEPTH: go to ERR.
    - Else: go to DATA with byte index 0.
  - DATA: shift each accepted byte into the word register (mem_wdata <= {mem_wdata[23:0],byte_in}). After the 4th byte, go to WRITE.
  - WRITE: one cycle. mem_we=1 with the current mem_addr and the assembled mem_wdata; byte_ready=0.
    - On exit: words_loaded+1, mem_addr+1.
    - If words_loaded+1==N, go to DONE; else go to DATA.
    - Latency: 1 cycle from 4th-byte acceptance to the write strobe.
  - DONE: busy=0, done=1, cpu_rst=0. start begins a new load (back to the LEN_HI path, cpu_rst=1 again the next cycle).
  - ERR: busy=0, err=1, cpu_rst=1, byte_ready=0. Exit only via start or RST.
- mem_addr advances modulo DEPTH. N=DEPTH fills address DEPTH-1 last; no wrap write occurs.
- start while busy is ignored. start and RST together: RST wins.
- byte_valid while byte_ready=0 does not transfer; the host must hold the byte.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the Nth word (or after LEN_LO when N=0), state CSUM accepts one more byte.
  - Expected value: XOR of all 4N data bytes.
  - Match: go to DONE. Mismatch: go to ERR.
  - The final word is still written before the checksum is checked.
- Not defined: no CSUM state; DONE follows the last WRITE directly.

Test Plan:
- Reset then idle, no start: cpu_rst=1, byte_ready=0, mem_we=0, done=0 for 10 cycles.
- Load N=2: send 00 02 20 01 00 05 00 00 00 0A. Expected: mem_we pulses with addr 0 data 0x20010005, then addr 1 data 0x0000000A. Then done=1, cpu_rst=0, words_loaded=2.
- Backpressure: same stream with byte_valid gapped every other cycle, plus a byte_valid held through a WRITE cycle. Expected: identical writes, no byte lost or duplicated.
- Oversize: ADDR_W=6, header 00 41 (N=65). Expected: err=1, cpu_rst=1, no mem_we, byte_ready=0.
- RST asserted after 2 data bytes of the first word. Expected: all outputs at reset values next cycle, no mem_we. A subsequent full N=1 load succeeds at addr 0.
- With LOADER_CHECKSUM_EN defined: N=1, word 0x12345678, checksum 0x08 gives done=1. Checksum 0x00 gives err=1, with the word still written at addr 0.
